// File: rtl/apb3_requester_traffic_gen_pkg.sv
// Shared types and pattern helpers for the APB3 requester traffic generator.
// Contents:
//   state_e       - sequencer states
//   phase_e       - sweep direction, write sweep first, then optional read-back
//   pattern_addr  - address of transfer idx
//   pattern_data  - data word of transfer idx for a given seed
// The pattern helpers work on 64-bit values and callers truncate the result
// to the bus width. Modular arithmetic keeps the low bits exact, so this is
// correct for any bus width up to 64 bits.
package apb3_requester_traffic_gen_pkg;

  localparam int unsigned PatW = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic {
    PH_WRITE = 1'b0,
    PH_READ  = 1'b1
  } phase_e;

  function automatic logic [PatW-1:0] pattern_addr(input logic [PatW-1:0] base,
                                                   input logic [PatW-1:0] stride,
                                                   input logic [PatW-1:0] idx);
    return base + idx * stride;
  endfunction

  // The increment is 0x01 in every byte lane of the data bus.
  function automatic logic [PatW-1:0] pattern_data(input logic [PatW-1:0] seed,
                                                   input logic [PatW-1:0] idx,
                                                   input int unsigned     n_bytes);
    logic [PatW-1:0] inc;
    inc = '0;
    for (int unsigned b = 0; b < PatW / 8; b++) begin
      if (b < n_bytes) begin
        inc[8*b +: 8] = 8'h01;
      end else begin
        inc[8*b +: 8] = 8'h00;
      end
    end
    return seed + idx * inc;
  endfunction

endpackage

// File: rtl/apb3_requester_traffic_gen_if.sv
// APB3 bus bundle between the traffic generator and a completer.
// master: drives paddr/psel/penable/pwrite/pwdata; samples prdata/pready/pslverr.
// slave : the mirror image, used by the completer or the testbench.
interface apb3_requester_traffic_gen_if #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32
);
  logic [AddressWidth-1:0] paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic [DataWidth-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb3_requester_traffic_gen_cmp.sv
// Completion bookkeeping for the traffic generator.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   clear_i             - zero both counters (start of a run)
//   xfer_done_i         - a transfer completes this cycle
//   phase_i             - direction of the completing transfer
//   pslverr_i, prdata_i - completer response
//   exp_data_i          - expected read data for the completing transfer
//   slverr_count_o      - saturating count of PSLVERR responses
//   mismatch_count_o    - saturating count of read-back compare failures
// An erroring read is counted as an error only and is never compared.
module apb3_requester_traffic_gen_cmp
  import apb3_requester_traffic_gen_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned SlvW      = 5,
  parameter int unsigned MisW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 xfer_done_i,
  input  phase_e               phase_i,
  input  logic                 pslverr_i,
  input  logic [DataWidth-1:0] prdata_i,
  input  logic [DataWidth-1:0] exp_data_i,
  output logic [SlvW-1:0]      slverr_count_o,
  output logic [MisW-1:0]      mismatch_count_o
);

  logic [SlvW-1:0] slv_q, slv_d;
  logic [MisW-1:0] mis_q, mis_d;

  // Next counter values: clear on start, otherwise saturating increments.
  always_comb begin
    slv_d = slv_q;
    mis_d = mis_q;
    if (clear_i) begin
      slv_d = '0;
      mis_d = '0;
    end else if (xfer_done_i) begin
      if (pslverr_i) begin
        if (slv_q != {SlvW{1'b1}}) begin
          slv_d = slv_q + SlvW'(1);
        end else begin
          slv_d = slv_q;
        end
      end else if ((phase_i == PH_READ) && (prdata_i != exp_data_i)) begin
        if (mis_q != {MisW{1'b1}}) begin
          mis_d = mis_q + MisW'(1);
        end else begin
          mis_d = mis_q;
        end
      end else begin
        mis_d = mis_q;
      end
    end else begin
      slv_d = slv_q;
      mis_d = mis_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_q <= '0;
      mis_q <= '0;
    end else begin
      slv_q <= slv_d;
      mis_q <= mis_d;
    end
  end

  assign slverr_count_o   = slv_q;
  assign mismatch_count_o = mis_q;

endmodule

// File: rtl/apb3_requester_traffic_gen.sv
// APB3 requester traffic generator.
// A run writes a known pattern sweep and can then read the same pattern back
// and compare it. Runs use an optional idle gap between transfers and abort
// on a PREADY timeout.
// Ports:
//   clk, rst         - clock and asynchronous active-high reset
//   start_i          - run request pulse, accepted only in IDLE
//   gap_i            - idle cycles between transfers (latched at start)
//   readback_en_i    - add a read-back sweep (latched at start)
//   seed_i           - data pattern seed (latched at start)
//   apb              - APB3 master side
//   busy_o, done_o   - run in progress / one-cycle end-of-run pulse
//   timeout_o        - run aborted on PREADY timeout (held until next start)
//   slverr_count_o   - PSLVERR responses in this run
//   mismatch_count_o - read-back compare failures in this run
// All outputs are registers. Each output's next value is derived from the
// next state, so outputs change on the same edge as the state.
module apb3_requester_traffic_gen
  import apb3_requester_traffic_gen_pkg::*;
#(
  parameter int unsigned             AddressWidth  = 32,
  parameter int unsigned             DataWidth     = 32,
  parameter int unsigned             TransferCount = 8,
  parameter logic [AddressWidth-1:0] BaseAddress   = '0,
  parameter int unsigned             AddressStride = DataWidth / 8,
  parameter int unsigned             MaxGap        = 15,
  parameter int unsigned             TimeoutCycles = 64,
  localparam int unsigned            GapW = $clog2(MaxGap + 1),
  localparam int unsigned            SlvW = $clog2(2 * TransferCount + 1),
  localparam int unsigned            MisW = $clog2(TransferCount + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [GapW-1:0]             gap_i,
  input  logic                        readback_en_i,
  input  logic [DataWidth-1:0]        seed_i,
  apb3_requester_traffic_gen_if.master apb,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic [SlvW-1:0]             slverr_count_o,
  output logic [MisW-1:0]             mismatch_count_o
);

  localparam int unsigned IdxW = (TransferCount > 1) ? $clog2(TransferCount) : 1;
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  state_e                  state_q, state_d;
  phase_e                  phase_q, phase_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [GapW-1:0]         gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                    rb_q, rb_d;
  logic [DataWidth-1:0]    seed_q, seed_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    timeout_q, timeout_d;
  logic [AddressWidth-1:0] paddr_q, paddr_d;
  logic                    psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [DataWidth-1:0]    pwdata_q, pwdata_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    clear_s, xfer_done_s;
  logic [DataWidth-1:0]    exp_data_s;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_WRITE;
      idx_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      rb_q      <= 1'b0;
      seed_q    <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      rb_q      <= rb_d;
      seed_q    <= seed_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: sweep sequencing, gap countdown and PREADY timeout.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    rb_d        = rb_q;
    seed_d      = seed_q;
    tmo_d       = tmo_q;
    timeout_d   = timeout_q;
    clear_s     = 1'b0;
    xfer_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          gap_d     = gap_i;
          rb_d      = readback_en_i;
          seed_d    = seed_i;
          timeout_d = 1'b0;
          clear_s   = 1'b1;
          phase_d   = PH_WRITE;
          idx_d     = '0;
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        tmo_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          xfer_done_s = 1'b1;
          if ((idx_q == IdxW'(TransferCount - 1)) &&
              !((phase_q == PH_WRITE) && rb_q)) begin
            state_d = ST_DONE;
          end else begin
            if (idx_q == IdxW'(TransferCount - 1)) begin
              phase_d = PH_READ;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
            // A zero gap keeps psel high straight into the next SETUP.
            if (gap_q == '0) begin
              state_d = ST_SETUP;
            end else begin
              gap_cnt_d = gap_q - GapW'(1);
              state_d   = ST_GAP;
            end
          end
        end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_SETUP;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: bus and status values for the state being entered.
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      ST_SETUP: begin
        psel_d   = 1'b1;
        busy_d   = 1'b1;
        paddr_d  = AddressWidth'(pattern_addr(PatW'(BaseAddress), PatW'(AddressStride),
                                              PatW'(idx_d)));
        pwrite_d = (phase_d == PH_WRITE);
        if (phase_d == PH_WRITE) begin
          pwdata_d = DataWidth'(pattern_data(PatW'(seed_d), PatW'(idx_d), DataWidth / 8));
        end else begin
          pwdata_d = '0;
        end
      end
      ST_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_GAP: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      ST_IDLE: begin
        done_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign exp_data_s = DataWidth'(pattern_data(PatW'(seed_q), PatW'(idx_q), DataWidth / 8));

  apb3_requester_traffic_gen_cmp #(
    .DataWidth (DataWidth),
    .SlvW      (SlvW),
    .MisW      (MisW)
  ) u_cmp (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (clear_s),
    .xfer_done_i      (xfer_done_s),
    .phase_i          (phase_q),
    .pslverr_i        (apb.pslverr),
    .prdata_i         (apb.prdata),
    .exp_data_i       (exp_data_s),
    .slverr_count_o   (slverr_count_o),
    .mismatch_count_o (mismatch_count_o)
  );

  assign apb.paddr   = paddr_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_apb3_requester_traffic_gen.sv
// Directed testbench for apb3_requester_traffic_gen (default parameters:
// 8 transfers, base 0, stride 4, 32-bit bus, timeout 64).
// The bench acts as an APB completer backed by an 8-word memory. It can add
// wait states, return PSLVERR, corrupt read data, or hang on chosen transfers.
module tb_apb3_requester_traffic_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  gap;
  logic        rb;
  logic [31:0] seed;
  logic        busy, done, timeout;
  logic [4:0]  slv;
  logic [3:0]  mis;

  int checks = 0;
  int errors = 0;

  // completer configuration (-1 = feature off)
  int wait_states = 0;
  int err_w = -1, err_r = -1, flip_r = -1, hang_w = -1;
  int clr_req = 0;

  // monitor state, owned by the completer process
  int          cyc = 0, clr_ack = 0, acc_k = 0, low_run = 0, unstable = 0, done_cyc = 0, ti;
  bit          saw_first = 1'b0, seen_done = 1'b0, busy_at_done = 1'b0, tmo_first = 1'b0;
  logic [31:0] mem [8];
  logic [31:0] s_addr, s_wdata;
  logic [31:0] log_addr[$], log_wdata[$];
  bit          log_write[$];
  int          log_cyc[$], acc_lens[$], setup_cycs[$], gaps[$];

  apb3_requester_traffic_gen_if #(.AddressWidth(32), .DataWidth(32)) apb_if ();

  apb3_requester_traffic_gen dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .gap_i            (gap),
    .readback_en_i    (rb),
    .seed_i           (seed),
    .apb              (apb_if),
    .busy_o           (busy),
    .done_o           (done),
    .timeout_o        (timeout),
    .slverr_count_o   (slv),
    .mismatch_count_o (mis)
  );

  always #5 clk = ~clk;

  // Completer and monitor: respond on the falling edge, log each completed transfer.
  always @(negedge clk) begin
    cyc++;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      log_addr.delete(); log_wdata.delete(); log_write.delete(); log_cyc.delete();
      acc_lens.delete(); setup_cycs.delete(); gaps.delete();
      saw_first = 1'b0; seen_done = 1'b0; unstable = 0; low_run = 0;
    end
    if (rst) begin
      acc_k = 0;
      apb_if.pready = 1'b0; apb_if.pslverr = 1'b0; apb_if.prdata = 32'h0;
    end else begin
      if (apb_if.psel && !apb_if.penable) begin
        if (saw_first) gaps.push_back(low_run);
        else tmo_first = timeout;
        saw_first = 1'b1; low_run = 0;
        setup_cycs.push_back(cyc);
        s_addr = apb_if.paddr; s_wdata = apb_if.pwdata; acc_k = 0;
        apb_if.pready = 1'b0; apb_if.pslverr = 1'b0;
      end else if (apb_if.psel && apb_if.penable) begin
        if (apb_if.paddr !== s_addr || apb_if.pwdata !== s_wdata) unstable++;
        ti = int'(apb_if.paddr[4:2]);
        if (!(apb_if.pwrite && ti == hang_w) && acc_k == wait_states) begin
          apb_if.pready  = 1'b1;
          apb_if.pslverr = apb_if.pwrite ? (ti == err_w) : (ti == err_r);
          if (apb_if.pwrite) mem[ti] = apb_if.pwdata;
          else apb_if.prdata = mem[ti] ^ ((ti == flip_r) ? 32'h1 : 32'h0);
          log_addr.push_back(apb_if.paddr); log_wdata.push_back(apb_if.pwdata);
          log_write.push_back(apb_if.pwrite); log_cyc.push_back(cyc);
          acc_lens.push_back(acc_k + 1);
        end else begin
          apb_if.pready = 1'b0; apb_if.pslverr = 1'b0;
        end
        acc_k++;
      end else begin
        apb_if.pready = 1'b0; apb_if.pslverr = 1'b0;
        if (saw_first) low_run++;
      end
      if (done) begin
        done_cyc = cyc; busy_at_done = busy; seen_done = 1'b1;
      end
    end
  end

  task automatic cfg(input int ws, input int ew, input int er, input int fr, input int hw);
    wait_states = ws; err_w = ew; err_r = er; flip_r = fr; hang_w = hw;
    clr_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] g, input logic r, input logic [31:0] s);
    gap = g; rb = r; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2000 && !seen_done; k++) @(negedge clk);
    checks++;
    if (!seen_done) begin
      $display("FAIL run_done: done seen=%0b, required 1 within 2000 cycles", seen_done);
      errors++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({apb_if.psel, apb_if.penable, apb_if.pwrite, busy, done, timeout} !== 6'b0 ||
        apb_if.paddr !== 32'h0 || apb_if.pwdata !== 32'h0 || slv !== 5'd0 || mis !== 4'd0) begin
      $display("FAIL reset_outputs: psel=%0b pen=%0b paddr=%h pwdata=%h busy=%0b done=%0b tmo=%0b slv=%0d mis=%0d, required all 0",
               apb_if.psel, apb_if.penable, apb_if.paddr, apb_if.pwdata, busy, done, timeout, slv, mis);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, ed;
    int gsum;
    cfg(0, -1, -1, -1, -1);
    run(4'd0, 1'b1, 32'h11223344);
    checks++;
    if (log_addr.size() != 16) begin
      $display("FAIL b2b_count: got %0d transfers, required 16", log_addr.size()); errors++;
    end
    for (int i = 0; i < log_addr.size() && i < 16; i++) begin
      ea = 32'(i % 8) * 32'd4;
      ed = (i < 8) ? 32'h11223344 + 32'(i) * 32'h01010101 : 32'h0;
      checks++;
      if (log_addr[i] !== ea || log_wdata[i] !== ed || log_write[i] !== (i < 8)) begin
        $display("FAIL b2b_xfer[%0d]: addr=%h data=%h wr=%0b, required addr=%h data=%h wr=%0b",
                 i, log_addr[i], log_wdata[i], log_write[i], ea, ed, (i < 8)); errors++;
      end
    end
    checks++;
    if (log_wdata.size() > 1 && log_wdata[1] !== 32'h12233445) begin
      $display("FAIL b2b_data1: got %h, required 12233445", log_wdata[1]); errors++;
    end
    gsum = 0;
    foreach (gaps[k]) gsum += gaps[k];
    checks++;
    if (gaps.size() != 15 || gsum != 0) begin
      $display("FAIL b2b_psel_drop: %0d gaps totalling %0d idle cycles, required 15 gaps of 0", gaps.size(), gsum); errors++;
    end
    checks++;
    if (mis !== 4'd0 || slv !== 5'd0 || timeout !== 1'b0) begin
      $display("FAIL b2b_counters: mis=%0d slv=%0d tmo=%0b, required 0 0 0", mis, slv, timeout); errors++;
    end
    checks++;
    if (setup_cycs.size() == 0 || done_cyc - setup_cycs[0] != 32) begin
      $display("FAIL b2b_latency: done %0d cycles after first SETUP, required 32", done_cyc - setup_cycs[0]); errors++;
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      $display("FAIL b2b_busy_done: busy=%0b during done, required 0", busy_at_done); errors++;
    end
  endtask

  task automatic test_gap();
    int bad;
    cfg(0, -1, -1, -1, -1);
    run(4'd3, 1'b0, 32'hFFFFFFFE);
    checks++;
    if (log_addr.size() != 8 || log_write[0] !== 1'b1 || log_write[7] !== 1'b1) begin
      $display("FAIL gap_count: got %0d transfers, required 8 writes", log_addr.size()); errors++;
    end
    checks++;
    if (log_wdata[1] !== 32'h010100FF || log_wdata[7] !== 32'h07070705 || log_addr[7] !== 32'h1C) begin
      $display("FAIL gap_wrap_data: d1=%h d7=%h a7=%h, required 010100ff 07070705 0000001c",
               log_wdata[1], log_wdata[7], log_addr[7]); errors++;
    end
    bad = 0;
    foreach (gaps[k]) if (gaps[k] != 3) bad++;
    checks++;
    if (gaps.size() != 7 || bad != 0) begin
      $display("FAIL gap_idle: %0d gaps with %0d not equal to 3, required 7 gaps of 3", gaps.size(), bad); errors++;
    end
    checks++;
    if (log_cyc.size() != 8 || done_cyc - log_cyc[7] != 1 || done_cyc - setup_cycs[0] != 37) begin
      $display("FAIL gap_done_timing: done-last_access=%0d done-first_setup=%0d, required 1 and 37",
               done_cyc - log_cyc[7], done_cyc - setup_cycs[0]); errors++;
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      $display("FAIL gap_busy_done: busy=%0b, required 0", busy_at_done); errors++;
    end
  endtask

  task automatic test_mismatch();
    cfg(0, -1, -1, 5, -1);
    run(4'd0, 1'b1, 32'hCAFE0000);
    checks++;
    if (mis !== 4'd1 || slv !== 5'd0) begin
      $display("FAIL mismatch_counts: mis=%0d slv=%0d, required 1 0", mis, slv); errors++;
    end
  endtask

  task automatic test_wait_err();
    int bad;
    cfg(2, 2, 7, 7, -1);
    run(4'd1, 1'b1, 32'h00000080);
    checks++;
    if (slv !== 5'd2 || mis !== 4'd0) begin
      $display("FAIL werr_counts: slv=%0d mis=%0d, required 2 0", slv, mis); errors++;
    end
    bad = 0;
    foreach (acc_lens[k]) if (acc_lens[k] != 3) bad++;
    checks++;
    if (acc_lens.size() != 16 || bad != 0) begin
      $display("FAIL werr_access_len: %0d transfers, %0d not 3 cycles, required 16 of 3", acc_lens.size(), bad); errors++;
    end
    checks++;
    if (unstable != 0) begin
      $display("FAIL werr_stable: %0d ACCESS cycles with moving paddr/pwdata, required 0", unstable); errors++;
    end
  endtask

  task automatic test_timeout();
    cfg(0, -1, -1, -1, 3);
    run(4'd0, 1'b1, 32'h00000005);
    checks++;
    if (timeout !== 1'b1) begin
      $display("FAIL tmo_flag: timeout=%0b, required 1", timeout); errors++;
    end
    checks++;
    if (log_addr.size() != 3 || setup_cycs.size() != 4) begin
      $display("FAIL tmo_no_read: %0d completed, %0d setups, required 3 and 4", log_addr.size(), setup_cycs.size()); errors++;
    end
    checks++;
    if (setup_cycs.size() < 4 || done_cyc - setup_cycs[3] != 65) begin
      $display("FAIL tmo_duration: done %0d cycles after hung SETUP, required 65", done_cyc - setup_cycs[3]); errors++;
    end
    cfg(0, -1, -1, -1, -1);
    run(4'd0, 1'b0, 32'h00000005);
    checks++;
    if (tmo_first !== 1'b0 || timeout !== 1'b0 || log_addr.size() != 8) begin
      $display("FAIL tmo_clear: tmo@setup=%0b tmo=%0b xfers=%0d, required 0 0 8", tmo_first, timeout, log_addr.size()); errors++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    cfg(5, -1, -1, -1, -1);
    gap = 4'd0; rb = 1'b0; seed = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      #1;
      if (apb_if.psel && apb_if.penable && apb_if.pwrite && apb_if.paddr == 32'h10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      $display("FAIL rstmid_reach: ACCESS of write 4 seen=%0b, required 1", found); errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({apb_if.psel, apb_if.penable, apb_if.pwrite, busy, done, timeout} !== 6'b0 ||
        apb_if.paddr !== 32'h0 || apb_if.pwdata !== 32'h0 || slv !== 5'd0 || mis !== 4'd0) begin
      $display("FAIL rstmid_outputs: psel=%0b pen=%0b paddr=%h busy=%0b, required all 0",
               apb_if.psel, apb_if.penable, apb_if.paddr, busy); errors++;
    end
    checks++;
    if (log_addr.size() != 4) begin
      $display("FAIL rstmid_completed: %0d transfers completed, required 4", log_addr.size()); errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    cfg(0, -1, -1, -1, -1);
    run(4'd0, 1'b0, 32'h1);
    checks++;
    if (log_addr.size() != 8 || log_addr[0] !== 32'h0 || log_wdata[0] !== 32'h1) begin
      $display("FAIL rstmid_restart: xfers=%0d addr0=%h data0=%h, required 8 00000000 00000001",
               log_addr.size(), log_addr[0], log_wdata[0]); errors++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; gap = 4'd0; rb = 1'b0; seed = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_back_to_back();
    test_gap();
    test_mismatch();
    test_wait_err();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
